// File: rtl/game_pkg.sv
// Shared 24-game types: card width, hand shape, dealer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    localparam int CARD_W    = 4;
    localparam int NUM_CARDS = 4;
    localparam int MIN_VAL   = 1;
    localparam int MAX_VAL   = 9;
    localparam int STRIDE    = 4;
    localparam int MAX_TRIES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } dealer_state_t;

    // Packed hand: card i occupies bits [CARD_W*i +: CARD_W].
    typedef logic [NUM_CARDS-1:0][CARD_W-1:0] hand_t;

endpackage

// File: rtl/card_range_check.sv
// Combinational legality test of a card nibble against [MIN_V, MAX_V].
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module card_range_check
    import game_pkg::*;
#(
    parameter int MIN_V = MIN_VAL,
    parameter int MAX_V = MAX_VAL
) (
    input  logic [CARD_W-1:0] val,
    output logic              legal
);

    localparam logic [CARD_W-1:0] LO = CARD_W'(MIN_V);
    localparam logic [CARD_W-1:0] HI = CARD_W'(MAX_V);

    // Unsigned 4-bit window compare; out-of-range nibbles simply reject.
    assign legal = (val >= LO) && (val <= HI);

endmodule

// File: rtl/card_dealer.sv
// Deals NUM_CARDS legal card values from the LFSR by strided rejection sampling.
// Latency: NUM_CARDS*STRIDE cycles from deal_req edge to cards_valid when every sample is legal.
// Backpressure: hand is held in DONE until cards_ack or a new deal_req; LFSR throttled via rand_en.
module card_dealer
    import game_pkg::*;
#(
    parameter int NUM_CARDS = game_pkg::NUM_CARDS,
    parameter int MIN_VAL   = game_pkg::MIN_VAL,
    parameter int MAX_VAL   = game_pkg::MAX_VAL,
    parameter int STRIDE    = game_pkg::STRIDE,
    parameter int MAX_TRIES = game_pkg::MAX_TRIES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    deal_req,
    input  logic                    cards_ack,
    input  logic [3:0]              rand_in,
    output logic                    rand_en,
    output logic [4*NUM_CARDS-1:0]  cards_out,
    output logic                    cards_valid,
    output logic                    busy,
    output logic                    error
);

    localparam int IDX_W    = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
    localparam int STRIDE_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int TRIES_W  = $clog2(MAX_TRIES + 1);

    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_CARDS - 1);
    localparam logic [STRIDE_W-1:0] STRIDE_LAST = STRIDE_W'(STRIDE - 1);
    localparam logic [TRIES_W-1:0]  TRIES_MAX   = TRIES_W'(MAX_TRIES);

    typedef logic [NUM_CARDS-1:0][CARD_W-1:0] dealer_hand_t;

    dealer_state_t state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [TRIES_W-1:0]  tries_q, tries_d;
    dealer_hand_t        shadow_q, shadow_d;
    dealer_hand_t        cards_out_q, cards_out_d;
    logic                cards_valid_q, cards_valid_d;
    logic                error_q, error_d;

    dealer_hand_t hand_next;
    logic         sample_legal;
    logic         eval_edge;

    card_range_check #(
        .MIN_V (MIN_VAL),
        .MAX_V (MAX_VAL)
    ) u_range (
        .val   (rand_in),
        .legal (sample_legal)
    );

    // LFSR advances and busy are decoded straight from the registered state.
    assign rand_en     = (state_q == ST_FILL);
    assign busy        = (state_q == ST_FILL);
    assign cards_out   = cards_out_q;
    assign cards_valid = cards_valid_q;
    assign error       = error_q;

    // Next-state: stride/tries counting, shadow fill, atomic hand publish.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        stride_d    = stride_q;
        tries_d     = tries_q;
        shadow_d    = shadow_q;
        cards_out_d = cards_out_q;
        eval_edge   = (stride_q == STRIDE_LAST);
        hand_next   = shadow_q;
        hand_next[idx_q] = rand_in;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (deal_req) begin
                    state_d  = ST_FILL;
                    idx_d    = '0;
                    stride_d = '0;
                    tries_d  = '0;
                end else if (state_q == ST_DONE && cards_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                stride_d = eval_edge ? '0 : stride_q + 1'b1;
                if (eval_edge) begin
                    tries_d = tries_q + 1'b1;
                    if (sample_legal) begin
                        shadow_d = hand_next;
                        if (idx_q == IDX_LAST) begin
                            // Whole hand lands in one edge so cards_out is never partial.
                            cards_out_d = hand_next;
                            state_d     = ST_DONE;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                    // Completion on the last allowed try still wins over the error.
                    if (state_d != ST_DONE && tries_d == TRIES_MAX) begin
                        state_d = ST_ERR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cards_valid_d = (state_d == ST_DONE);
        error_d       = (state_d == ST_ERR);
    end

    // State and registered outputs; synchronous reset abandons any deal in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            stride_q      <= '0;
            tries_q       <= '0;
            shadow_q      <= '0;
            cards_out_q   <= '0;
            cards_valid_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            stride_q      <= stride_d;
            tries_q       <= tries_d;
            shadow_q      <= shadow_d;
            cards_out_q   <= cards_out_d;
            cards_valid_q <= cards_valid_d;
            error_q       <= error_d;
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer against a sample-list model of the dealing rules.
// Latency: n/a.
// Backpressure: n/a.
module tb_card_dealer;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        deal_req = 1'b0;
    logic        cards_ack = 1'b0;
    logic [3:0]  rand_in;
    logic        rand_en;
    logic [15:0] cards_out;
    logic        cards_valid;
    logic        busy;
    logic        error;

    logic [3:0]  rand_drv = 4'd0;
    logic        lfsr_mode = 1'b0;
    logic        lfsr_load = 1'b0;
    logic [3:0]  lfsr = 4'd0;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] last_hand = 16'h0;
    logic [3:0]  samp_q[$];

    localparam logic [3:0] SEED = 4'b1010;

    card_dealer dut (
        .clk         (clk),
        .rst         (rst),
        .deal_req    (deal_req),
        .cards_ack   (cards_ack),
        .rand_in     (rand_in),
        .rand_en     (rand_en),
        .cards_out   (cards_out),
        .cards_valid (cards_valid),
        .busy        (busy),
        .error       (error)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lfsr_step(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // Upstream registered LFSR, advanced only when the dealer enables it.
    always @(posedge clk) begin
        if (lfsr_load) lfsr <= SEED;
        else if (rand_en) lfsr <= lfsr_step(lfsr);
    end

    assign rand_in = lfsr_mode ? lfsr : rand_drv;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pad_samples();
        while (samp_q.size() < 32) samp_q.push_back(4'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".cards_out"}, 32'(cards_out), 32'h0);
        chk({tag, ".valid"}, 32'(cards_valid), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".error"}, 32'(error), 32'h0);
        chk({tag, ".rand_en"}, 32'(rand_en), 32'h0);
    endtask

    // One deal: samp_q[e] is the value seen on evaluation e (every 4th cycle).
    // Model: first four legal samples within 32 evaluations form the hand.
    task automatic run_deal(input string tag, input bit with_ack, input int req_pulse_at);
        logic [15:0] exp_hand;
        logic [15:0] tmp;
        int          acc;
        int          exp_lat;
        bit          exp_err;
        int          lat;
        bit          got_err;
        int          en_cnt;

        exp_hand = last_hand;
        tmp      = 16'h0;
        acc      = 0;
        exp_err  = 1'b1;
        exp_lat  = 4 * 32;
        for (int e = 0; e < 32; e++) begin
            if (samp_q[e] >= 4'd1 && samp_q[e] <= 4'd9) begin
                tmp[4*acc +: 4] = samp_q[e];
                acc++;
                if (acc == 4) begin
                    exp_err  = 1'b0;
                    exp_lat  = 4 * (e + 1);
                    exp_hand = tmp;
                    break;
                end
            end
        end

        deal_req  = 1'b1;
        cards_ack = with_ack;
        tick();
        deal_req  = 1'b0;
        cards_ack = 1'b0;
        chk({tag, ".busy_on_start"}, 32'(busy), 32'h1);
        chk({tag, ".error_cleared"}, 32'(error), 32'h0);

        en_cnt  = int'(rand_en);
        lat     = 0;
        got_err = 1'b0;
        for (int k = 1; k <= 4 * 32 + 8; k++) begin
            if (k % 4 == 0 && (k / 4 - 1) < samp_q.size()) rand_drv = samp_q[k/4-1];
            else rand_drv = 4'($urandom_range(0, 15));
            deal_req = (k == req_pulse_at);
            tick();
            deal_req = 1'b0;
            if (cards_valid || error) begin
                lat     = k;
                got_err = error;
                break;
            end
            en_cnt += int'(rand_en);
        end

        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".error"}, 32'(got_err), 32'(exp_err));
        chk({tag, ".valid"}, 32'(cards_valid), 32'(!exp_err));
        chk({tag, ".cards_out"}, 32'(cards_out), 32'(exp_hand));
        chk({tag, ".rand_en_cycles"}, 32'(en_cnt), 32'(exp_lat));
        chk({tag, ".rand_en_off"}, 32'(rand_en), 32'h0);
        if (!exp_err) last_hand = exp_hand;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] s;
        logic [3:0] seq[$];

        // Reset held two cycles, then idle.
        rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) tick();
        chk_reset_outputs("idle");

        // All-legal deal.
        samp_q = '{4'd3, 4'd5, 4'd7, 4'd9};
        pad_samples();
        run_deal("legal", 1'b0, 0);
        chk("legal.hand9753", 32'(cards_out), 32'h9753);

        // Rejection sampling.
        samp_q = '{4'd0, 4'd12, 4'd2, 4'd15, 4'd4, 4'd6, 4'd10, 4'd8};
        pad_samples();
        run_deal("reject", 1'b0, 0);
        chk("reject.hand8642", 32'(cards_out), 32'h8642);

        // Exhausted tries, then recovery from ERR.
        samp_q.delete();
        pad_samples();
        run_deal("exhaust", 1'b0, 0);
        samp_q = '{4'd1, 4'd2, 4'd3, 4'd4};
        pad_samples();
        run_deal("recover", 1'b0, 0);

        // Ack in DONE drops valid, holds the hand.
        cards_ack = 1'b1;
        tick();
        cards_ack = 1'b0;
        chk("ack.valid", 32'(cards_valid), 32'h0);
        chk("ack.cards_out", 32'(cards_out), 32'(last_hand));
        chk("ack.busy", 32'(busy), 32'h0);
        tick();
        chk("ack.idle_hold", 32'(cards_out), 32'(last_hand));

        // deal_req together with cards_ack from DONE re-deals.
        samp_q = '{4'd6, 4'd6, 4'd1, 4'd9};
        pad_samples();
        run_deal("predone", 1'b0, 0);
        samp_q = '{4'd2, 4'd8, 4'd5, 4'd7};
        pad_samples();
        run_deal("req_ack", 1'b1, 0);

        // deal_req in FILL cycle 5 is ignored.
        samp_q = '{4'd9, 4'd1, 4'd9, 4'd1};
        pad_samples();
        run_deal("midreq", 1'b0, 5);

        // Reset in FILL cycle 9 abandons the deal.
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            rand_drv = 4'd5;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        last_hand = 16'h0;
        samp_q = '{4'd4, 4'd3, 4'd2, 4'd1};
        pad_samples();
        run_deal("after_rst", 1'b0, 0);

        // Real LFSR source seeded 1010.
        samp_q.delete();
        seq.delete();
        s = SEED;
        for (int i = 0; i < 4 * 32; i++) begin
            seq.push_back(s);
            s = lfsr_step(s);
        end
        for (int e = 0; e < 32; e++) samp_q.push_back(seq[4*e+3]);
        lfsr_load = 1'b1;
        tick();
        lfsr_load = 1'b0;
        lfsr_mode = 1'b1;
        run_deal("lfsr", 1'b0, 0);
        chk("lfsr.no_error", 32'(error), 32'h0);
        lfsr_mode = 1'b0;

        // Randomized deals, some biased towards rejects.
        for (int r = 0; r < 6; r++) begin
            samp_q.delete();
            for (int e = 0; e < 32; e++) begin
                if (r % 2 == 1) samp_q.push_back(4'($urandom_range(8, 15)));
                else samp_q.push_back(4'($urandom_range(0, 15)));
            end
            run_deal("rand", 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Draws four 24-game card values from the 4-bit LFSR random source.
- Throttles the LFSR through its enable input and rejects out-of-range nibbles by rejection sampling.
- Spaces accepted samples so that consecutive cards come from independent shift windows.
- Presents a packed, stable four-card hand to the game controller with a valid/ack handshake.

Parameters:
- NUM_CARDS, 4: cards per hand.
- MIN_VAL, 1: smallest legal card value.
- MAX_VAL, 9: largest legal card value; must be at most 15.
- STRIDE, 4: LFSR advances per evaluation; must be at least 1.
- MAX_TRIES, 32: evaluations allowed per deal before the block declares an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- deal_req  in  1  start a new deal; sampled every cycle.
- cards_ack  in  1  controller has consumed the hand.
- rand_in  in  4  current LFSR output, registered upstream.
- rand_en  out  1  LFSR advance enable.
- cards_out  out  4*NUM_CARDS  packed hand; card i is at bits [4i+3:4i].
- cards_valid  out  1  hand on cards_out is complete and stable.
- busy  out  1  a deal is in progress.
- error  out  1  MAX_TRIES was exhausted.

Behaviour:
- States: IDLE, FILL, DONE, ERR.
- Reset values: state=IDLE; cards_out=0; cards_valid=0; busy=0; error=0; rand_en=0; all counters=0.
- Reset mid-FILL abandons the deal. The partial hand is discarded.
- IDLE:
  - deal_req=1 -> FILL.
  - On entry to FILL: slot idx=0, stride_cnt=0, tries=0.
- FILL:
  - rand_en=1 and busy=1, combinationally from state.
  - Every FILL cycle, stride_cnt increments, wrapping at STRIDE-1.
  - The edge where stride_cnt==STRIDE-1 is an evaluation edge:
    - tries increments.
    - If MIN_VAL<=rand_in<=MAX_VAL, rand_in is written to shadow slot idx and idx increments.
    - Otherwise the sample is dropped.
  - When the accepted sample fills slot NUM_CARDS-1: shadow copies to cards_out in the same edge, then -> DONE.
  - Otherwise, if tries reaches MAX_TRIES on this edge -> ERR. Completion takes priority over the tries limit.
  - deal_req during FILL is ignored.
- Latency: with every sample accepted, cards_valid rises NUM_CARDS*STRIDE cycles after the edge that samples deal_req (16 with defaults).
- DONE:
  - cards_valid=1; rand_en=0; cards_out held.
  - cards_ack=1 -> IDLE. cards_valid falls and cards_out keeps its value.
  - deal_req=1 -> FILL (re-deal). deal_req wins if asserted together with cards_ack.
- ERR:
  - error=1; cards_out keeps the previous hand; cards_valid=0.
  - deal_req=1 -> FILL and clears error.
- cards_out changes only on entry to DONE or on rst. It is never partially updated.
- Duplicate card values are legal.
- No dependency on the LFSR period: values 0 and 10..15 simply reject.
- Comparisons are unsigned, 4-bit.

Decomposition:
- Shared package game_pkg:
  - CARD_W=4, NUM_CARDS=4, MIN_VAL=1, MAX_VAL=9.
  - State encoding enum for dealer states.
  - Packed hand type (NUM_CARDS x CARD_W), also used by the solver/display stages.
- Natural sub-module: card_range_check, a combinational legality test of rand_in against MIN_VAL/MAX_VAL.
  - Reused by the user-input entry stage.
- Stride/tries counters and the shadow register file stay in card_dealer.

Test Plan:
1. Reset and idle:
   - Stimulus: rst for 2 cycles, then idle 5 cycles.
   - Required: cards_out=0; cards_valid, busy, error and rand_en all 0.
2. All-legal deal:
   - Stimulus: bench drives rand_in=3,5,7,9 on evaluation edges; pulse deal_req.
   - Required: cards_valid rises exactly 16 cycles after the deal_req edge; cards_out=16'h9753.
   - Required: rand_en is high for 16 cycles.
3. Rejection:
   - Stimulus: evaluation samples 0,12,2,15,4,6,10,8.
   - Required: cards_out=16'h8642; valid rises after 32 cycles; tries=8.
4. Error:
   - Stimulus: rand_in held at 0 with MAX_TRIES=32.
   - Required: error=1 after 128 FILL cycles; cards_valid=0; cards_out unchanged.
   - Required: a following deal_req with legal samples clears error and yields a hand.
5. Handshake:
   - Stimulus: in DONE, assert cards_ack.
   - Required: valid falls the next cycle and cards_out is held.
   - Stimulus: deal_req together with cards_ack.
   - Required: state -> FILL.
6. Mid-deal events:
   - Stimulus: deal_req pulse in FILL cycle 5.
   - Required: ignored; latency unchanged.
   - Stimulus: rst in FILL cycle 9.
   - Required: IDLE with all outputs at reset values, then a fresh deal completes normally.
   - Stimulus: real psuedo-random source seeded 1010, STRIDE=4.
   - Required: hand completes without error.
